barrett_param_gen: RTL and testbench

- Upstream setup stage for the Barrett reducer.
- Takes a new NTT modulus m and computes every per-modulus constant the reducer consumes: k, k_shft_ah, k_shft_ahxmd, md = floor(2^k/m) and mx3 = 3*m.
- Uses an FSM with a bit-serial restoring divider. It runs once per modulus change, so area matters more than latency.
- Outputs are registered and held stable, so they wire directly to the reducer's constant inputs.

---
 rtl/barrett_param_gen.sv | 135 +++++++++++++
 tb/tb_barrett_param_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/barrett_param_gen.sv
// Per-modulus constant generator for the Barrett reducer: validates m, finds its bit length n
// and computes k = 2n, n-1, n+1, md = floor(2^k/m) with a bit-serial restoring divider, and 3m.
module barrett_param_gen #(
  parameter int unsigned NBITS       = 128,
  parameter int unsigned LOG2POLYDEG = 13
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic [NBITS-1:0]           m_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       err_o,
  output logic [$clog2(NBITS)+1:0]   k_o,
  output logic [$clog2(NBITS):0]     k_shft_ah_o,
  output logic [$clog2(NBITS):0]     k_shft_ahxmd_o,
  output logic [NBITS:0]             md_o,
  output logic [NBITS+1:0]           mx3_o
);

  localparam int unsigned NW = $clog2(NBITS) + 1;
  localparam int unsigned KW = $clog2(NBITS) + 2;

  typedef enum logic [1:0] {StIdle, StNorm, StDiv, StFin} state_e;

  state_e           state_q;
  logic [NBITS-1:0] m_q;
  logic             busy_q, done_q, err_q;
  logic [KW-1:0]    k_q, cnt_q;
  logic [NW-1:0]    ah_q, ahxmd_q;
  logic [NBITS:0]   md_q, rem_q, quo_q;
  logic [NBITS+1:0] mx3_q;

  logic             bad_mod;
  logic [NW-1:0]    n_msb;
  logic [KW-1:0]    k_val;
  logic [NBITS:0]   r2, rem_next, quo_next;
  logic [NBITS+1:0] mx3_val;
  logic             ge;

  assign bad_mod = (m_i[LOG2POLYDEG:0] != (LOG2POLYDEG + 1)'(1)) || (m_i == NBITS'(1));

  always_comb begin
    n_msb = '0;
    for (int unsigned i = 0; i < NBITS; i++) begin
      if (m_q[i]) n_msb = NW'(i + 1);
    end
  end

  assign k_val   = {n_msb, 1'b0};
  assign mx3_val = {2'b00, m_q} + {1'b0, m_q, 1'b0};

  // r < m always holds, so shifting r left never loses a set bit.
  assign r2       = rem_q << 1;
  assign ge       = (r2 >= {1'b0, m_q});
  assign rem_next = ge ? (r2 - {1'b0, m_q}) : r2;
  assign quo_next = (quo_q << 1) | {{NBITS{1'b0}}, ge};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      m_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      ah_q    <= '0;
      ahxmd_q <= '0;
      md_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      mx3_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            m_q     <= m_i;
            busy_q  <= 1'b1;
            err_q   <= bad_mod;
            state_q <= StNorm;
          end
        end
        StNorm: begin
          // A rejected modulus only passes through here so its done lands one cycle after accept.
          if (err_q) begin
            k_q     <= '0;
            ah_q    <= '0;
            ahxmd_q <= '0;
            md_q    <= '0;
            mx3_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFin;
          end else begin
            k_q     <= k_val;
            ah_q    <= n_msb - NW'(1);
            ahxmd_q <= n_msb + NW'(1);
            mx3_q   <= mx3_val;
            quo_q   <= '0;
            rem_q   <= (NBITS + 1)'(1);
            cnt_q   <= k_val;
            state_q <= StDiv;
          end
        end
        StDiv: begin
          rem_q <= rem_next;
          quo_q <= quo_next;
          cnt_q <= cnt_q - KW'(1);
          if (cnt_q == KW'(1)) begin
            md_q    <= quo_next;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StFin;
          end
        end
        StFin: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign k_o            = k_q;
  assign k_shft_ah_o    = ah_q;
  assign k_shft_ahxmd_o = ahxmd_q;
  assign md_o           = md_q;
  assign mx3_o          = mx3_q;

endmodule

// File: tb/tb_barrett_param_gen.sv
// Directed bench for barrett_param_gen: two 16-bit instances (LOG2POLYDEG = 1 and 11) sharing
// one clock, selected per run by sel.
module tb_barrett_param_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        start_r = 1'b0;
  logic [15:0] m_r = '0;

  logic        busy_a, done_a, err_a, busy_b, done_b, err_b;
  logic [5:0]  k_a, k_b;
  logic [4:0]  ah_a, ah_b, xmd_a, xmd_b;
  logic [16:0] md_a, md_b;
  logic [17:0] mx3_a, mx3_b;

  logic        busy, done, err;
  logic [5:0]  k;
  logic [4:0]  ah, xmd;
  logic [16:0] md;
  logic [17:0] mx3;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  barrett_param_gen #(.NBITS(16), .LOG2POLYDEG(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r & ~sel), .m_i(m_r),
    .busy_o(busy_a), .done_o(done_a), .err_o(err_a), .k_o(k_a), .k_shft_ah_o(ah_a),
    .k_shft_ahxmd_o(xmd_a), .md_o(md_a), .mx3_o(mx3_a)
  );

  barrett_param_gen #(.NBITS(16), .LOG2POLYDEG(11)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_r & sel), .m_i(m_r),
    .busy_o(busy_b), .done_o(done_b), .err_o(err_b), .k_o(k_b), .k_shft_ah_o(ah_b),
    .k_shft_ahxmd_o(xmd_b), .md_o(md_b), .mx3_o(mx3_b)
  );

  always_comb begin
    busy = sel ? busy_b : busy_a;
    done = sel ? done_b : done_a;
    err  = sel ? err_b  : err_a;
    k    = sel ? k_b    : k_a;
    ah   = sel ? ah_b   : ah_a;
    xmd  = sel ? xmd_b  : xmd_a;
    md   = sel ? md_b   : md_a;
    mx3  = sel ? mx3_b  : mx3_a;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic check_consts(input string tag, input logic e, input int kk, input int a,
                              input int x, input longint mdv, input longint m3);
    check_eq({tag, "_err"}, 64'(err), 64'(e));
    check_eq({tag, "_k"}, 64'(k), 64'(kk));
    check_eq({tag, "_ah"}, 64'(ah), 64'(a));
    check_eq({tag, "_ahxmd"}, 64'(xmd), 64'(x));
    check_eq({tag, "_md"}, 64'(md), 64'(mdv));
    check_eq({tag, "_mx3"}, 64'(mx3), 64'(m3));
  endtask

  // Leaves the bench #1 after the accepting edge T.
  task automatic issue(input logic s, input logic [15:0] mv);
    @(negedge clk);
    sel = s;
    m_r = mv;
    start_r = 1'b1;
    @(posedge clk); #1;
    start_r = 1'b0;
  endtask

  // Sample j is taken #1 after edge T+j, i.e. the value seen by edge T+j+1. A good modulus shows
  // done at j = 2n+1 (edge T+2n+2), a rejected one at j = 1; busy is high for exactly j < lat.
  // poke_at >= 0 drives a stray start with poke_m during that sample's cycle.
  task automatic wait_done(input string tag, input int lat, input int poke_at,
                           input logic [15:0] poke_m);
    int  j = 0;
    int  nbusy = 0;
    bit  seen = 0;
    while (j < 300) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (busy) nbusy++;
      if (j == poke_at) begin
        m_r = poke_m;
        start_r = 1'b1;
      end else begin
        start_r = 1'b0;
      end
      @(posedge clk); #1;
      j++;
    end
    start_r = 1'b0;
    check_eq({tag, "_lat"}, seen ? 64'(j) : 64'hFFFF, 64'(lat));
    check_eq({tag, "_busycyc"}, 64'(nbusy), 64'(lat));
    check_eq({tag, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic done_drops(input string tag);
    @(posedge clk); #1;
    check_eq({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int     nb;
    int     dpulses;
    longint mv, expmd;
    logic [3:0] r;

    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check_eq("rst_busy", 64'(busy), 64'd0);
      check_eq("rst_done", 64'(done), 64'd0);
      check_consts("rst", 1'b0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // m = 13: n = 4, md = floor(256/13) = 19.
    issue(1'b0, 16'd13);
    wait_done("m13", 9, -1, 16'd0);
    check_consts("m13", 1'b0, 8, 3, 5, 19, 39);
    done_drops("m13");

    // 7 mod 4 = 3 is rejected, then m = 1 is rejected.
    issue(1'b0, 16'd7);
    wait_done("m7", 1, -1, 16'd0);
    check_consts("m7", 1'b1, 0, 0, 0, 0, 0);
    done_drops("m7");
    issue(1'b0, 16'd1);
    wait_done("m1", 1, -1, 16'd0);
    check_consts("m1", 1'b1, 0, 0, 0, 0, 0);
    done_drops("m1");

    // m = 12289: n = 14, md = floor(2^28/12289) = 21843. A stray start mid-DIV is ignored.
    issue(1'b1, 16'd12289);
    wait_done("m12289", 29, 6, 16'd61441);
    check_consts("m12289", 1'b0, 28, 13, 15, 21843, 36867);

    // Start during the done cycle is ignored; held one more cycle it is accepted.
    m_r = 16'd61441;
    start_r = 1'b1;
    @(posedge clk); #1;
    check_eq("b2b_done_drops", 64'(done), 64'd0);
    check_eq("b2b_ignored", 64'(busy), 64'd0);
    @(posedge clk); #1;
    start_r = 1'b0;
    check_eq("b2b_accepted", 64'(busy), 64'd1);
    // m = 61441: n = 16, md = floor(2^32/61441) = 69903 (61441*69904 exceeds 2^32).
    wait_done("m61441", 33, -1, 16'd0);
    check_consts("m61441", 1'b0, 32, 15, 17, 69903, 184323);
    done_drops("m61441");

    // Reset pulse mid-DIV: everything clears at once and no done follows.
    issue(1'b1, 16'd12289);
    repeat (8) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_consts("midrst", 1'b0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dpulses = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dpulses++;
    end
    check_eq("midrst_no_done", 64'(dpulses), 64'd0);
    issue(1'b1, 16'd12289);
    wait_done("postrst", 29, -1, 16'd0);
    check_consts("postrst", 1'b0, 28, 13, 15, 21843, 36867);
    done_drops("postrst");

    // Random moduli m = r*4096 + 1 against a direct floor(2^(2n)/m).
    for (int it = 0; it < 6; it++) begin
      r  = 4'($urandom_range(1, 15));
      mv = longint'({r, 12'h001});
      nb = 0;
      for (int b = 0; b < 16; b++) if (mv[b]) nb = b + 1;
      expmd = (64'd1 << (2 * nb)) / mv;
      issue(1'b1, 16'(mv));
      wait_done("rand", 2 * nb + 1, -1, 16'd0);
      check_consts("rand", 1'b0, 2 * nb, nb - 1, nb + 1, expmd, 3 * mv);
      done_drops("rand");
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
